// File: rtl/calc1_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc1_pkg : command/response codes and driver FSM state type for calc1.
// Rev 1.0
// ----------------------------------------------------------------------------
package calc1_pkg;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND1 = 3'd1,
    ST_SEND2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/calc1_port_driver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc1_port_driver_if : request, calculator and response signals of one port.
// Rev 1.0
// ----------------------------------------------------------------------------
interface calc1_port_driver_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int TAG_W  = 2
);

  logic              req_valid;
  logic              req_ready;
  logic [CMD_W-1:0]  req_cmd;
  logic [DATA_W-1:0] req_op1;
  logic [DATA_W-1:0] req_op2;
  logic [TAG_W-1:0]  req_tag;
  logic [CMD_W-1:0]  calc_cmd_out;
  logic [DATA_W-1:0] calc_data_out;
  logic [1:0]        calc_resp_in;
  logic [DATA_W-1:0] calc_data_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_resp;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              spurious_resp;

  // slave: the driver itself; master: request source, calculator and consumer
  modport slave (
    input  req_valid, req_cmd, req_op1, req_op2, req_tag,
    input  calc_resp_in, calc_data_in, rsp_ready,
    output req_ready, calc_cmd_out, calc_data_out,
    output rsp_valid, rsp_resp, rsp_data, rsp_tag, spurious_resp
  );

  modport master (
    output req_valid, req_cmd, req_op1, req_op2, req_tag,
    output calc_resp_in, calc_data_in, rsp_ready,
    input  req_ready, calc_cmd_out, calc_data_out,
    input  rsp_valid, rsp_resp, rsp_data, rsp_tag, spurious_resp
  );

endinterface
`default_nettype wire

// File: rtl/calc1_drv_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc1_drv_timer : saturating wait counter, expired on the TIMEOUT_CYC-th enabled cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
module calc1_drv_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == C_LAST);
  assign expired   = enable && w_at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc1_port_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc1_port_driver : serialises one request onto a calc1 port and returns its response.
// CALC1_DRV_TIMEOUT_EN adds a TIMEOUT_CYC wait limit.          Rev 1.0
// ----------------------------------------------------------------------------
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 4,
  parameter int TAG_W       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                c_clk,
  input  logic                reset,
  calc1_port_driver_if.slave  bus
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("calc1_port_driver: TIMEOUT_CYC must be at least 1");
  end

  drv_state_t        r_state, w_state_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic [CMD_W-1:0]  r_cmd_out, w_cmd_out_nxt;
  logic [DATA_W-1:0] r_data_out, w_data_out_nxt;
  logic [DATA_W-1:0] r_op2, w_op2_nxt;
  logic [TAG_W-1:0]  r_tag, w_tag_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [1:0]        r_rsp_resp, w_rsp_resp_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [TAG_W-1:0]  r_rsp_tag, w_rsp_tag_nxt;
  logic              r_spur, w_spur_nxt;
  logic              w_resp_seen;
  logic              w_expired;

  assign w_resp_seen = (bus.calc_resp_in != RESP_NONE);

`ifdef CALC1_DRV_TIMEOUT_EN
  logic w_in_wait;
  assign w_in_wait = (r_state == ST_WAIT);

  calc1_drv_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (c_clk),
    .rst     (reset),
    .clear   (!w_in_wait),
    .enable  (w_in_wait),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_cmd_out   <= '0;
      r_data_out  <= '0;
      r_op2       <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_resp  <= RESP_NONE;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_spur      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_cmd_out   <= w_cmd_out_nxt;
      r_data_out  <= w_data_out_nxt;
      r_op2       <= w_op2_nxt;
      r_tag       <= w_tag_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_tag   <= w_rsp_tag_nxt;
      r_spur      <= w_spur_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_cmd_out_nxt   = r_cmd_out;
    w_data_out_nxt  = r_data_out;
    w_op2_nxt       = r_op2;
    w_tag_nxt       = r_tag;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_tag_nxt   = r_rsp_tag;
    // any calculator response outside WAIT is flagged and otherwise ignored
    w_spur_nxt      = r_spur | (w_resp_seen && (r_state != ST_WAIT));

    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_state_nxt     = ST_SEND1;
          w_req_ready_nxt = 1'b0;
          w_cmd_out_nxt   = bus.req_cmd;
          w_data_out_nxt  = bus.req_op1;
          w_op2_nxt       = bus.req_op2;
          w_tag_nxt       = bus.req_tag;
        end
      end
      ST_SEND1: begin
        w_state_nxt    = ST_SEND2;
        w_cmd_out_nxt  = '0;
        w_data_out_nxt = r_op2;
      end
      ST_SEND2: begin
        w_state_nxt    = ST_WAIT;
        w_cmd_out_nxt  = '0;
        w_data_out_nxt = '0;
      end
      ST_WAIT: begin
        // a response on the expiry cycle takes priority over the timeout
        if (w_resp_seen) begin
          w_state_nxt     = ST_HOLD;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_resp_nxt  = bus.calc_resp_in;
          w_rsp_data_nxt  = bus.calc_data_in;
          w_rsp_tag_nxt   = r_tag;
        end else if (w_expired) begin
          w_state_nxt     = ST_HOLD;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_resp_nxt  = RESP_TIMEOUT;
          w_rsp_data_nxt  = '0;
          w_rsp_tag_nxt   = r_tag;
        end
      end
      ST_HOLD: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
        w_cmd_out_nxt   = '0;
        w_data_out_nxt  = '0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.calc_cmd_out  = r_cmd_out;
  assign bus.calc_data_out = r_data_out;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_resp      = r_rsp_resp;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_tag       = r_rsp_tag;
  assign bus.spurious_resp = r_spur;

endmodule
`default_nettype wire
